// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: req/ack handshake with address, store data and load data.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory access with req/ack timeout, pipeline stall, branch/jump redirect, MEM/WB register.
// Optional MEM_STAGE_ALIGN_CHECK_EN: blocks unaligned accesses and raises a sticky misalign flag.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  in_write_reg,
  input  logic [31:0] in_write_data,
  input  logic [31:0] in_alu_result,
  input  logic        in_zero,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_pc_jump,
  input  logic [27:0] in_jump_inst,
  input  logic        in_branch,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic        in_mem_reg,
  input  logic        in_jump,
  mem_stage_if.master dmem,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] pc_target,
  output logic        bus_err,
  output logic [4:0]  out_write_reg,
  output logic [31:0] out_read_data,
  output logic [31:0] out_alu_result,
  output logic        out_reg_write,
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic        out_mem_reg
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state, state_next;
  logic [7:0] cnt;
  logic       mem_op, issue, req, abort, wb_kill;

  assign mem_op = in_mem_read | in_mem_write;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic bad_align;
  assign bad_align = mem_op & (in_alu_result[1:0] != 2'b00);
  assign issue     = mem_op & ~bad_align;
  assign wb_kill   = abort | bad_align;

  always_ff @(posedge clk) begin
    if (rst)            misalign <= 1'b0;
    else if (bad_align) misalign <= 1'b1;
  end
`else
  assign issue   = mem_op;
  assign wb_kill = abort;
`endif

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = in_mem_write;
  assign dmem.dmem_addr  = in_alu_result;
  assign dmem.dmem_wdata = in_write_data;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (issue && !dmem.dmem_ack)  state_next = S_WAIT;
      S_WAIT: if (dmem.dmem_ack || abort)   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Reset gates the bus request combinationally so a pending access drops immediately.
  always_comb begin
    req   = 1'b0;
    abort = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: req = issue;
        S_WAIT: begin
          req   = 1'b1;
          abort = !dmem.dmem_ack && (cnt == LAST);
        end
        default: req = 1'b0;
      endcase
    end
    stall = req & ~dmem.dmem_ack & ~abort;
  end

  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT || dmem.dmem_ack || abort) cnt <= '0;
    else if (cnt != 8'hFF)                               cnt <= cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)        bus_err <= 1'b0;
    else if (abort) bus_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_write_reg  <= '0;
      out_read_data  <= '0;
      out_alu_result <= '0;
      out_reg_write  <= 1'b0;
      out_mem_reg    <= 1'b0;
    end else if (stall) begin
      out_reg_write <= 1'b0;
      out_mem_reg   <= 1'b0;
    end else begin
      out_write_reg  <= in_write_reg;
      out_alu_result <= in_alu_result;
      out_read_data  <= (in_mem_read && req && dmem.dmem_ack) ? dmem.dmem_rdata : '0;
      out_reg_write  <= in_reg_write & ~wb_kill;
      out_mem_reg    <= in_mem_reg;
    end
  end

  always_comb begin
    redirect  = 1'b0;
    pc_target = in_pc;
    if (!rst && !stall) begin
      if (in_jump) begin
        redirect  = 1'b1;
        pc_target = {in_pc[31:28], in_jump_inst};
      end else if (in_branch && in_zero) begin
        redirect  = 1'b1;
        pc_target = in_pc_jump;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instruction stream vs. a latency-level model.
module tb_mem_stage;
  localparam int unsigned T    = 4;
  localparam int unsigned NONE = 99;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  in_write_reg;
  logic [31:0] in_write_data, in_alu_result, in_pc, in_pc_jump;
  logic [27:0] in_jump_inst;
  logic        in_zero, in_branch, in_mem_read, in_mem_write, in_reg_write, in_mem_reg, in_jump;
  logic        stall, redirect, bus_err, out_reg_write, out_mem_reg;
  logic [31:0] pc_target, out_read_data, out_alu_result;
  logic [4:0]  out_write_reg;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [31:0] ack_data;
  logic        exp_be = 1'b0;
  int unsigned obs_stall, obs_req;
  logic        obs_stable, obs_bubble, obs_quiet, obs_redirect;
  logic [31:0] obs_target;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .in_write_reg(in_write_reg), .in_write_data(in_write_data), .in_alu_result(in_alu_result),
    .in_zero(in_zero), .in_pc(in_pc), .in_pc_jump(in_pc_jump), .in_jump_inst(in_jump_inst),
    .in_branch(in_branch), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .in_mem_reg(in_mem_reg), .in_jump(in_jump),
    .dmem(bus),
    .stall(stall), .redirect(redirect), .pc_target(pc_target), .bus_err(bus_err),
    .out_write_reg(out_write_reg), .out_read_data(out_read_data), .out_alu_result(out_alu_result),
    .out_reg_write(out_reg_write),
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .out_mem_reg(out_mem_reg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1);
  end

  // Model: a request acked at cycle index lat completes then; beyond T cycles it is aborted at cycle T.
  function automatic int unsigned m_stall(input logic mop, input int unsigned lat);
    if (!mop) return 0;
    return (lat > T) ? T : lat;
  endfunction

  function automatic logic m_abort(input logic mop, input int unsigned lat);
    return mop && (lat > T);
  endfunction

  function automatic logic [32:0] m_redir();
    if (in_jump)               return {1'b1, in_pc[31:28], in_jump_inst};
    if (in_branch && in_zero)  return {1'b1, in_pc_jump};
    return {1'b0, in_pc};
  endfunction

  task automatic clear_inputs();
    in_write_reg = '0; in_write_data = '0; in_alu_result = '0; in_zero = 1'b0;
    in_pc = '0; in_pc_jump = '0; in_jump_inst = '0; in_branch = 1'b0;
    in_mem_read = 1'b0; in_mem_write = 1'b0; in_reg_write = 1'b0; in_mem_reg = 1'b0; in_jump = 1'b0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
  endtask

  task automatic rand_instr();
    logic [31:0] tmp;
    int unsigned kind;
    tmp = $urandom;
    in_alu_result = tmp & 32'hFFFF_FFFC;
    in_write_reg  = 5'($urandom);
    in_write_data = $urandom;
    in_pc         = $urandom;
    in_pc_jump    = $urandom;
    in_jump_inst  = 28'($urandom) & 28'hFFF_FFFC;
    kind          = $urandom_range(0, 3);
    in_mem_read   = (kind == 1) || (kind == 3);
    in_mem_write  = (kind == 2) || (kind == 3);
    in_jump       = ($urandom_range(0, 5) == 0);
    in_branch     = 1'($urandom);
    in_zero       = 1'($urandom);
    in_reg_write  = 1'($urandom);
    in_mem_reg    = 1'($urandom);
    ack_data      = $urandom;
  endtask

  // Drives one instruction through the stage; lat is the cycle index of the ack (NONE = never).
  task automatic exec(input int unsigned lat);
    int unsigned cyc;
    logic mop, stall_now;
    mop = in_mem_read | in_mem_write;
    cyc = 0; obs_stall = 0; obs_req = 0;
    obs_stable = 1'b1; obs_bubble = 1'b1; obs_quiet = 1'b1; obs_redirect = 1'b0; obs_target = '0;
    forever begin
      bus.dmem_ack   = mop && (cyc == lat);
      bus.dmem_rdata = bus.dmem_ack ? ack_data : $urandom;
      @(negedge clk);
      stall_now = stall;
      if (bus.dmem_req === 1'b1) obs_req++;
      if (bus.dmem_addr !== in_alu_result || bus.dmem_wdata !== in_write_data || bus.dmem_we !== in_mem_write)
        obs_stable = 1'b0;
      obs_redirect = redirect;
      obs_target   = pc_target;
      if (stall_now === 1'b1) begin
        obs_stall++;
        if (redirect !== 1'b0) obs_quiet = 1'b0;
      end
      @(posedge clk); #1;
      bus.dmem_ack = 1'b0;
      if (stall_now !== 1'b1) break;
      if (out_reg_write !== 1'b0 || out_mem_reg !== 1'b0) obs_bubble = 1'b0;
      cyc++;
      if (cyc > 64) begin
        tests++; fails++;
        $display("FAIL exec_bound: stall=%b after %0d cycles, required release", stall_now, cyc);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rand_instr();
    in_mem_read = 1'b1; in_jump = 1'b1;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    tests++; if (bus.dmem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b, required 0", bus.dmem_req); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b, required 0", stall); end
    tests++; if (redirect !== 1'b0) begin fails++; $display("FAIL rst_redirect: got %b, required 0", redirect); end
    tests++;
    if ({out_write_reg, out_read_data, out_alu_result, out_reg_write, out_mem_reg, bus_err} !== '0) begin
      fails++;
      $display("FAIL rst_outputs: wr=%h rd=%h alu=%h rw=%b mr=%b be=%b, required all 0",
               out_write_reg, out_read_data, out_alu_result, out_reg_write, out_mem_reg, bus_err);
    end
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL rst_misalign: got %b, required 0", misalign); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    exp_be = 1'b0;
  endtask

  task automatic test_zero_wait_load();
    clear_inputs();
    in_mem_read = 1'b1; in_alu_result = 32'h100; in_write_reg = 5'd9;
    in_reg_write = 1'b1; in_mem_reg = 1'b1; ack_data = 32'hDEADBEEF;
    exec(0);
    tests++; if (obs_stall !== 0) begin fails++; $display("FAIL zw_stall: got %0d cycles, required 0", obs_stall); end
    tests++; if (obs_req !== 1) begin fails++; $display("FAIL zw_req: got %0d req cycles, required 1", obs_req); end
    tests++; if (out_read_data !== 32'hDEADBEEF) begin fails++; $display("FAIL zw_rdata: got %h, required deadbeef", out_read_data); end
    tests++; if (out_reg_write !== 1'b1 || out_mem_reg !== 1'b1) begin
      fails++; $display("FAIL zw_ctrl: got rw=%b mr=%b, required 1 1", out_reg_write, out_mem_reg); end
    tests++; if (out_write_reg !== 5'd9) begin fails++; $display("FAIL zw_wreg: got %0d, required 9", out_write_reg); end
  endtask

  task automatic test_wait_store();
    clear_inputs();
    in_mem_write = 1'b1; in_alu_result = 32'h200; in_write_data = 32'h12345678; in_jump = 1'b1;
    in_pc = 32'hA000_0004; in_jump_inst = 28'h0000_100;
    exec(3);
    tests++; if (obs_stall !== 3) begin fails++; $display("FAIL ws_stall: got %0d cycles, required 3", obs_stall); end
    tests++; if (obs_req !== 4) begin fails++; $display("FAIL ws_req: got %0d req cycles, required 4", obs_req); end
    tests++; if (obs_stable !== 1'b1) begin fails++; $display("FAIL ws_bus_stable: got %b, required 1", obs_stable); end
    tests++; if (obs_bubble !== 1'b1) begin fails++; $display("FAIL ws_bubble: got %b, required 1", obs_bubble); end
    tests++; if (obs_quiet !== 1'b1) begin fails++; $display("FAIL ws_redirect_in_stall: got %b, required 1", obs_quiet); end
    tests++; if (obs_redirect !== 1'b1 || obs_target !== 32'hA000_0100) begin
      fails++; $display("FAIL ws_jump_release: got %b/%h, required 1/a0000100", obs_redirect, obs_target); end
    tests++; if (out_reg_write !== 1'b0 || out_read_data !== 32'h0) begin
      fails++; $display("FAIL ws_wb: got rw=%b rd=%h, required 0 0", out_reg_write, out_read_data); end
  endtask

  task automatic test_timeout();
    clear_inputs();
    in_mem_read = 1'b1; in_alu_result = 32'h400; in_reg_write = 1'b1; in_mem_reg = 1'b1; in_write_reg = 5'd3;
    exec(NONE);
    exp_be = 1'b1;
    tests++; if (obs_stall !== T) begin fails++; $display("FAIL to_stall: got %0d cycles, required %0d", obs_stall, T); end
    tests++; if (bus_err !== 1'b1) begin fails++; $display("FAIL to_bus_err: got %b, required 1", bus_err); end
    tests++; if (out_reg_write !== 1'b0 || out_read_data !== 32'h0) begin
      fails++; $display("FAIL to_wb: got rw=%b rd=%h, required 0 0", out_reg_write, out_read_data); end
    rand_instr();
    in_mem_read = 1'b1; in_mem_write = 1'b0; in_reg_write = 1'b1;
    exec(1);
    tests++; if (obs_stall !== 1) begin fails++; $display("FAIL to_next_stall: got %0d, required 1", obs_stall); end
    tests++; if (out_reg_write !== 1'b1 || out_read_data !== ack_data) begin
      fails++; $display("FAIL to_next_wb: got rw=%b rd=%h, required 1 %h", out_reg_write, out_read_data, ack_data); end
    tests++; if (bus_err !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b, required 1", bus_err); end
  endtask

  task automatic test_branch_jump();
    clear_inputs();
    in_branch = 1'b1; in_zero = 1'b1; in_pc_jump = 32'h40; in_pc = 32'h1000;
    exec(0);
    tests++; if (obs_redirect !== 1'b1 || obs_target !== 32'h40) begin
      fails++; $display("FAIL br_taken: got %b/%h, required 1/00000040", obs_redirect, obs_target); end
    in_zero = 1'b0;
    exec(0);
    tests++; if (obs_redirect !== 1'b0 || obs_target !== 32'h1000) begin
      fails++; $display("FAIL br_not_taken: got %b/%h, required 0/00001000", obs_redirect, obs_target); end
    in_branch = 1'b1; in_zero = 1'b1; in_jump = 1'b1; in_pc = 32'h30000010; in_jump_inst = 28'h0000080;
    exec(0);
    tests++; if (obs_redirect !== 1'b1 || obs_target !== 32'h30000080) begin
      fails++; $display("FAIL jump: got %b/%h, required 1/30000080", obs_redirect, obs_target); end
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    in_mem_read = 1'b1; in_alu_result = 32'h300; in_reg_write = 1'b1; in_mem_reg = 1'b1; in_write_reg = 5'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    tests++; if (bus.dmem_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL rmw_drop: got req=%b stall=%b, required 0 0", bus.dmem_req, stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    exp_be = 1'b0;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    tests++;
    if ({out_write_reg, out_read_data, out_alu_result, out_reg_write, out_mem_reg, bus_err} !== '0) begin
      fails++;
      $display("FAIL rmw_outputs: wr=%h rd=%h alu=%h rw=%b mr=%b be=%b, required all 0",
               out_write_reg, out_read_data, out_alu_result, out_reg_write, out_mem_reg, bus_err);
    end
    tests++; if (bus.dmem_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL rmw_late_ack: got req=%b stall=%b, required 0 0", bus.dmem_req, stall); end
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    tests++; if (out_read_data !== 32'h0 || out_reg_write !== 1'b0) begin
      fails++; $display("FAIL rmw_ack_ignored: got rd=%h rw=%b, required 0 0", out_read_data, out_reg_write); end
  endtask

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  task automatic test_misalign();
    clear_inputs();
    in_mem_read = 1'b1; in_alu_result = 32'h102; in_reg_write = 1'b1; in_mem_reg = 1'b1; ack_data = 32'h5555AAAA;
    exec(0);
    tests++; if (obs_req !== 0 || obs_stall !== 0) begin
      fails++; $display("FAIL ma_req: got req=%0d stall=%0d, required 0 0", obs_req, obs_stall); end
    tests++; if (misalign !== 1'b1) begin fails++; $display("FAIL ma_flag: got %b, required 1", misalign); end
    tests++; if (out_reg_write !== 1'b0 || out_read_data !== 32'h0) begin
      fails++; $display("FAIL ma_wb: got rw=%b rd=%h, required 0 0", out_reg_write, out_read_data); end
    in_alu_result = 32'h104;
    exec(0);
    tests++; if (out_reg_write !== 1'b1 || out_read_data !== ack_data || misalign !== 1'b1) begin
      fails++; $display("FAIL ma_next: got rw=%b rd=%h ma=%b, required 1 %h 1", out_reg_write, out_read_data, misalign, ack_data); end
  endtask
`endif

  task automatic test_back_to_back();
    int unsigned lat, es;
    logic mop, ab;
    logic [32:0] rd;
    for (int n = 0; n < 80; n++) begin
      rand_instr();
      lat = ($urandom_range(0, 9) == 0) ? NONE : $urandom_range(0, 6);
      mop = in_mem_read | in_mem_write;
      ab  = m_abort(mop, lat);
      es  = m_stall(mop, lat);
      rd  = m_redir();
      exec(lat);
      exp_be = exp_be | ab;
      tests++; if (obs_stall !== es) begin fails++; $display("FAIL b2b_stall[%0d]: got %0d, required %0d", n, obs_stall, es); end
      tests++; if (obs_req !== (mop ? es + 1 : 0)) begin
        fails++; $display("FAIL b2b_req[%0d]: got %0d, required %0d", n, obs_req, mop ? es + 1 : 0); end
      tests++; if (obs_stable !== 1'b1 || obs_bubble !== 1'b1 || obs_quiet !== 1'b1) begin
        fails++; $display("FAIL b2b_hold[%0d]: got stable=%b bubble=%b quiet=%b, required 1 1 1", n, obs_stable, obs_bubble, obs_quiet); end
      tests++; if ({obs_redirect, obs_target} !== rd) begin
        fails++; $display("FAIL b2b_redirect[%0d]: got %b/%h, required %b/%h", n, obs_redirect, obs_target, rd[32], rd[31:0]); end
      tests++; if (out_write_reg !== in_write_reg || out_alu_result !== in_alu_result || out_mem_reg !== in_mem_reg) begin
        fails++; $display("FAIL b2b_fields[%0d]: got %h %h %b, required %h %h %b", n, out_write_reg, out_alu_result, out_mem_reg,
                          in_write_reg, in_alu_result, in_mem_reg); end
      tests++; if (out_reg_write !== (in_reg_write & ~ab)) begin
        fails++; $display("FAIL b2b_regwrite[%0d]: got %b, required %b", n, out_reg_write, in_reg_write & ~ab); end
      tests++; if (out_read_data !== ((in_mem_read && !ab) ? ack_data : 32'h0)) begin
        fails++; $display("FAIL b2b_rdata[%0d]: got %h, required %h", n, out_read_data, (in_mem_read && !ab) ? ack_data : 32'h0); end
      tests++; if (bus_err !== exp_be) begin fails++; $display("FAIL b2b_bus_err[%0d]: got %b, required %b", n, bus_err, exp_be); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_zero_wait_load();
    test_wait_store();
    test_timeout();
    test_branch_jump();
    test_reset_mid_wait();
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    test_misalign();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
